// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state encodings, widths and parameter range check for the reset sequencer
`ifndef RST_SEQ_PKG_SV
`define RST_SEQ_PKG_SV
`define RST_SEQ_RANGE_CHK(lbl, val, lo, hi) \
  if ((val) < (lo) || (val) > (hi)) begin : lbl \
    $error("rst_seq: parameter %0d outside %0d..%0d", (val), (lo), (hi)); \
  end
package rst_seq_pkg;
  typedef enum logic [1:0] {
    ST_ASSERT    = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RELEASE   = 2'd2,
    ST_DONE      = 2'd3
  } rst_seq_state_e;
  localparam int RST_SEQ_CNT_W = 8;
  localparam int RST_SEQ_IDX_W = 3;
endpackage
`endif

// File: rtl/rst_sync.sv
// rst_sync: async-assert, sync-deassert 2-flop reset synchronizer (active-low in and out)
module rst_sync (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);
  logic [1:0] sync_q;
  // shift ones in after rst_n rises; any low level clears both flops at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], 1'b1};
  assign rst_sync_n = sync_q[1];
endmodule

// File: rtl/rst_seq.sv
// rst_seq: staggered release of NUM_DOM domain resets with lock gating and soft-reset handshake
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOM    = 4,
  parameter int ASSERT_CYC = 4,
  parameter int STAGE_DLY  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               lock,
  input  logic               soft_req,
  output logic               soft_ack,
  output logic [NUM_DOM-1:0] dom_rst,
  output logic               seq_done
);
  localparam logic [RST_SEQ_CNT_W-1:0] ASSERT_LAST = RST_SEQ_CNT_W'(ASSERT_CYC - 1);
  localparam logic [RST_SEQ_CNT_W-1:0] STAGE_LAST  = RST_SEQ_CNT_W'(STAGE_DLY - 1);
  localparam logic [RST_SEQ_IDX_W-1:0] IDX_LAST    = RST_SEQ_IDX_W'(NUM_DOM - 1);

  `RST_SEQ_RANGE_CHK(chk_num_dom, NUM_DOM, 1, 8)
  `RST_SEQ_RANGE_CHK(chk_assert_cyc, ASSERT_CYC, 1, 255)
  `RST_SEQ_RANGE_CHK(chk_stage_dly, STAGE_DLY, 1, 255)

  logic                     rst_int_n;
  rst_seq_state_e           state_q, state_d;
  logic [RST_SEQ_CNT_W-1:0] cnt_q, cnt_d;
  logic [RST_SEQ_IDX_W-1:0] idx_q, idx_d;
  logic [NUM_DOM-1:0]       dom_q, dom_d, rel_mask;
  logic                     done_q, done_d, ack_q, ack_d, pend_q, pend_d;
  logic                     stage_end, last_dom, restart;

  rst_sync u_rst_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rst_sync_n(rst_int_n)
  );

  assign rel_mask  = NUM_DOM'(1) << idx_q;
  assign stage_end = cnt_q == STAGE_LAST;
  assign last_dom  = idx_q == IDX_LAST;
  assign restart   = (state_q == ST_RELEASE && !lock) || (state_q == ST_DONE && (!lock || soft_req));

  // next-state: timed assert, wait for lock, staggered release, hold; lock loss or soft request restarts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;
    pend_d  = pend_q;
    ack_d   = 1'b0;
    case (state_q)
      ST_ASSERT: begin
        cnt_d   = (cnt_q == ASSERT_LAST) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == ASSERT_LAST) ? ST_WAIT_LOCK : ST_ASSERT;
      end
      ST_WAIT_LOCK: state_d = lock ? ST_RELEASE : ST_WAIT_LOCK;
      ST_RELEASE: if (lock) begin
        cnt_d = stage_end ? '0 : cnt_q + 1'b1;
        if (stage_end) begin
          dom_d = dom_q & ~rel_mask;
          idx_d = idx_q + 1'b1;
        end
        if (stage_end && last_dom) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          ack_d   = pend_q;
          pend_d  = 1'b0;
        end
      end
      ST_DONE: pend_d = pend_q | soft_req;
      default: ;
    endcase
    if (restart) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '1;
      done_d  = 1'b0;
    end
  end

  // sequencer state and registered outputs, forced to reset values by the synchronized reset
  always_ff @(posedge clk or negedge rst_int_n)
    if (!rst_int_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '1;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
    end

  assign dom_rst  = dom_q;
  assign seq_done = done_q;
  assign soft_ack = ack_q;
endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: directed and randomized checks of rst_seq against a release-timeline model
module tb_rst_seq;
  localparam int ND = 4, AC = 4, SD = 10;
  logic clk = 1'b0, rst_n = 1'b1, lock = 1'b0, soft_req = 1'b0;
  logic soft_ack, seq_done;
  logic [ND-1:0] dom_rst;
  int vecs = 0, miscmp = 0;
  int n = 0, sync = 0, e0 = 0, lk = -1, ack_n = -1;
  bit pend = 1'b0;
  int acks = 0, fall0_n = -1, done_n = -1, a0 = 0, r = 0;
  logic prev_dom0 = 1'b1, prev_done = 1'b0;

  always #5 clk = ~clk;

  rst_seq #(.NUM_DOM(ND), .ASSERT_CYC(AC), .STAGE_DLY(SD)) dut (
    .clk(clk), .rst_n(rst_n), .lock(lock), .soft_req(soft_req),
    .soft_ack(soft_ack), .dom_rst(dom_rst), .seq_done(seq_done)
  );

  function automatic logic [ND-1:0] exp_dom();
    logic [ND-1:0] v;
    for (int k = 0; k < ND; k++) v[k] = !(lk >= 0 && n >= lk + (k + 1) * SD);
    return v;
  endfunction

  function automatic logic exp_done();
    return lk >= 0 && n >= lk + ND * SD;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      miscmp++;
      $error("FAIL %s edge=%0d got=%0h exp=%0h", tag, n, got, exp);
    end
  endtask

  // Timeline model: a sequence starts at edge e0, lock is accepted at edge lk, domain k frees at lk+(k+1)*SD
  task automatic model_edge();
    int last;
    bit done_pre;
    if (!rst_n) return;
    if (sync < 2) begin
      sync++;
      if (sync == 2) begin n = 0; e0 = 0; lk = -1; end
      return;
    end
    n++;
    last = lk + ND * SD;
    if (lk < 0) begin
      if (n > e0 + AC && lock) lk = n;
    end else begin
      done_pre = n > last;
      if (!lock || (done_pre && soft_req)) begin
        if (done_pre && soft_req) pend = 1'b1;
        e0 = n;
        lk = -1;
      end else if (n == last && pend) begin
        ack_n = n;
        pend = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("dom_rst", 32'(dom_rst), 32'(exp_dom()));
    chk("seq_done", 32'(seq_done), 32'(exp_done()));
    chk("soft_ack", 32'(soft_ack), 32'(sync == 2 && ack_n == n));
    if (soft_ack === 1'b1) begin acks++; soft_req = 1'b0; end
    if (prev_dom0 && !dom_rst[0]) fall0_n = n;
    if (!prev_done && seq_done) done_n = n;
    prev_dom0 = dom_rst[0];
    prev_done = seq_done;
  endtask

  task automatic rst_pulse();
    #3 rst_n = 1'b0;
    #1;
    chk("async_dom_rst", 32'(dom_rst), 32'hF);
    chk("async_seq_done", 32'(seq_done), 32'h0);
    chk("async_soft_ack", 32'(soft_ack), 32'h0);
    sync = 0; lk = -1; pend = 1'b0; ack_n = -1; soft_req = 1'b0;
    step();
    step();
    fall0_n = -1; done_n = -1;
    rst_n = 1'b1;
  endtask

  task automatic run_done(input int max);
    for (int i = 0; i < max && seq_done !== 1'b1; i++) step();
    chk("reach_done", 32'(seq_done), 32'h1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    lock = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    run_done(100);
    chk("pwr_fall0", fall0_n, 15);
    chk("pwr_done", done_n, 45);
    chk("pwr_acks", acks, 0);

    lock = 1'b0;
    rst_pulse();
    for (int i = 0; i < 40 && !(sync == 2 && n >= 20); i++) step();
    lock = 1'b1;
    run_done(100);
    chk("lock_late_fall0", fall0_n, 31);
    chk("lock_late_done", done_n, 61);

    repeat (5) step();
    a0 = acks;
    soft_req = 1'b1;
    step();
    r = n;
    chk("soft_all_ones", 32'(dom_rst), 32'hF);
    chk("soft_done_low", 32'(seq_done), 32'h0);
    run_done(100);
    chk("soft_fall0", fall0_n - r, 15);
    chk("soft_done", done_n - r, 45);
    repeat (3) step();
    chk("soft_ack_count", acks - a0, 1);

    lock = 1'b0;
    step();
    lock = 1'b1;
    for (int i = 0; i < 100 && dom_rst !== 4'b1100; i++) step();
    chk("reach_1100", 32'(dom_rst), 32'hC);
    lock = 1'b0;
    step();
    r = n;
    chk("lockloss_all_ones", 32'(dom_rst), 32'hF);
    lock = 1'b1;
    run_done(100);
    chk("lockloss_fall0", fall0_n - r, 15);
    chk("lockloss_done", done_n - r, 45);

    a0 = acks;
    soft_req = 1'b1;
    repeat (21) step();
    lock = 1'b0;
    step();
    lock = 1'b1;
    run_done(100);
    repeat (3) step();
    chk("soft_lockloss_acks", acks - a0, 1);

    a0 = acks;
    soft_req = 1'b1;
    repeat (26) step();
    rst_pulse();
    run_done(100);
    chk("rst_mid_fall0", fall0_n, 15);
    chk("rst_mid_done", done_n, 45);
    chk("rst_mid_acks", acks - a0, 0);

    repeat (3000) begin
      lock = $urandom_range(0, 63) != 0;
      if (!soft_req && $urandom_range(0, 31) == 0) soft_req = 1'b1;
      if ($urandom_range(0, 999) == 0) rst_pulse();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end
endmodule
